regfile_wb_arbiter: RTL and testbench

Write-port arbiter and scheduler for the single-write-port 32x32 register file. It merges two writeback sources into the register file write port. The primary source is the in-order pipeline WB stage. The secondary source is late/deferred writes, such as loads completing after a dcache miss. Deferred writes are buffered in a small FIFO and drained into idle write-port cycles. The block also exports a pending-register mask for hazard detection, and forces a pipeline stall when a deferred write has waited too long.

---
 rtl/regfile_wb_pkg.sv | 17 +
 rtl/regfile_wb_arbiter_if.sv | 27 ++
 rtl/wb_fifo.sv | 70 +++++++
 rtl/regfile_wb_arbiter.sv | 119 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 369 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_wb_pkg.sv
// Shared types for the register-file writeback arbiter: FIFO entry layout and FSM states.
package regfile_wb_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
    logic        kill;
  } wb_entry_t;

  typedef enum logic [0:0] {
    NORMAL,
    FORCE
  } wb_state_e;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus: WB-stage source, deferred source with handshake, and register-file side.
interface regfile_wb_arbiter_if;
  logic        a_valid;
  logic [4:0]  a_addr;
  logic [31:0] a_data;
  logic        b_valid;
  logic        b_ready;
  logic [4:0]  b_addr;
  logic [31:0] b_data;
  logic        regwrite;
  logic [4:0]  writeaddr;
  logic [31:0] writedata;
  logic        stall;
  logic [31:0] pending;
  logic        busy;
  logic        conflict;

  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    input  b_ready, regwrite, writeaddr, writedata, stall, pending, busy, conflict
  );

  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    output b_ready, regwrite, writeaddr, writedata, stall, pending, busy, conflict
  );
endinterface

// File: rtl/wb_fifo.sv
// Circular buffer of deferred writes with per-entry kill-by-address and a live-address mask.
module wb_fifo
  import regfile_wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        push_i,
  input  logic [4:0]  push_addr_i,
  input  logic [31:0] push_data_i,
  input  logic        pop_i,
  input  logic        kill_i,
  input  logic [4:0]  kill_addr_i,
  output logic        full_o,
  output logic        empty_o,
  output wb_entry_t   head_o,
  output logic [31:0] live_mask_o
);
  localparam int unsigned PtrW = $clog2(DEPTH);

  wb_entry_t        mem_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PtrW-1:0]  rd_ptr_q, wr_ptr_q;
  logic [PtrW:0]    count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      valid_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // Only occupied slots are compared, so a slot being refilled this cycle is never hit.
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (kill_i && valid_q[i] && mem_q[i].addr == kill_addr_i) mem_q[i].kill <= 1'b1;
      end
      if (pop_i) begin
        valid_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q          <= rd_ptr_q + PtrW'(1);
      end
      if (push_i) begin
        mem_q[wr_ptr_q].addr <= push_addr_i;
        mem_q[wr_ptr_q].data <= push_data_i;
        mem_q[wr_ptr_q].kill <= 1'b0;
        valid_q[wr_ptr_q]    <= 1'b1;
        wr_ptr_q             <= wr_ptr_q + PtrW'(1);
      end
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + (PtrW + 1)'(1);
        2'b01:   count_q <= count_q - (PtrW + 1)'(1);
        default: ;
      endcase
    end
  end

  assign full_o  = (count_q == (PtrW + 1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  always_comb begin
    live_mask_o = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && !mem_q[i].kill) live_mask_o[mem_q[i].addr] = 1'b1;
    end
    live_mask_o[REG_ZERO] = 1'b0;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Merges WB-stage writes and buffered deferred writes onto the single register-file write port.
module regfile_wb_arbiter
  import regfile_wb_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned MAX_WAIT = 8
) (
  input logic                 clk_i,
  input logic                 rst_i,
  regfile_wb_arbiter_if.slave bus
);
  localparam int unsigned WaitW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  logic        a_wr, fifo_full, fifo_empty, head_live, head_dead, drain, pop, push;
  wb_entry_t   head;
  logic [31:0] live_mask;

  wb_state_e        state_q, state_d;
  logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
  logic             conflict_q, conflict_d;
  logic             regwrite_q, regwrite_d;
  logic [4:0]       writeaddr_q, writeaddr_d;
  logic [31:0]      writedata_q, writedata_d;

  assign a_wr      = bus.a_valid && (bus.a_addr != REG_ZERO);
  assign head_live = !fifo_empty && !head.kill;
  assign head_dead = !fifo_empty && head.kill;
  assign drain     = head_live && !bus.a_valid;
  assign pop       = drain || head_dead;

  // A same-cycle A write to the same register supersedes the deferred one.
  assign bus.b_ready = !rst_i && !fifo_full;
  assign push = bus.b_valid && bus.b_ready && (bus.b_addr != REG_ZERO) &&
                !(a_wr && (bus.a_addr == bus.b_addr));

  wb_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (push),
    .push_addr_i (bus.b_addr),
    .push_data_i (bus.b_data),
    .pop_i       (pop),
    .kill_i      (a_wr),
    .kill_addr_i (bus.a_addr),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .head_o      (head),
    .live_mask_o (live_mask)
  );

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    conflict_d = conflict_q;
    case (state_q)
      NORMAL: begin
        if (pop || fifo_empty) begin
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WaitW'(MAX_WAIT - 1)) begin
          state_d = FORCE;
        end else begin
          wait_cnt_d = wait_cnt_q + WaitW'(1);
        end
      end
      FORCE: begin
        if (bus.a_valid) conflict_d = 1'b1;
        if (pop || fifo_empty) begin
          state_d    = NORMAL;
          wait_cnt_d = '0;
        end
      end
      default: state_d = NORMAL;
    endcase
  end

  always_comb begin
    regwrite_d  = 1'b0;
    writeaddr_d = writeaddr_q;
    writedata_d = writedata_q;
    if (a_wr) begin
      regwrite_d  = 1'b1;
      writeaddr_d = bus.a_addr;
      writedata_d = bus.a_data;
    end else if (drain) begin
      regwrite_d  = 1'b1;
      writeaddr_d = head.addr;
      writedata_d = head.data;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= NORMAL;
      wait_cnt_q  <= '0;
      conflict_q  <= 1'b0;
      regwrite_q  <= 1'b0;
      writeaddr_q <= '0;
      writedata_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      conflict_q  <= conflict_d;
      regwrite_q  <= regwrite_d;
      writeaddr_q <= writeaddr_d;
      writedata_q <= writedata_d;
    end
  end

  assign bus.regwrite  = regwrite_q;
  assign bus.writeaddr = writeaddr_q;
  assign bus.writedata = writedata_q;
  assign bus.stall     = (state_q == FORCE);
  assign bus.pending   = rst_i ? '0 : live_mask;
  assign bus.busy      = !rst_i && !fifo_empty;
  assign bus.conflict  = conflict_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus random traffic against a queue model.
module tb_regfile_wb_arbiter;
  localparam int DEPTH    = 4;
  localparam int MAX_WAIT = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  regfile_wb_arbiter_if bus ();

  regfile_wb_arbiter #(
    .DEPTH    (DEPTH),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, want finished");
    $fatal(1, "watchdog");
  end

  // Reference model: queue of deferred writes in program order plus head-age tracking.
  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    bit          kill;
  } ent_t;

  ent_t        q[$];
  bit          m_force, m_conflict;
  int          m_age;
  logic        exp_rw;
  logic [4:0]  exp_wa;
  logic [31:0] exp_wd;

  function automatic logic [31:0] model_pending();
    logic [31:0] m = '0;
    foreach (q[i]) if (!q[i].kill) m[q[i].addr] = 1'b1;
    m[0] = 1'b0;
    return m;
  endfunction

  task automatic drive(bit av, int aa, logic [31:0] ad, bit bv, int ba, logic [31:0] bd);
    bus.a_valid = av;
    bus.a_addr  = 5'(aa);
    bus.a_data  = ad;
    bus.b_valid = bv;
    bus.b_addr  = 5'(ba);
    bus.b_data  = bd;
  endtask

  // Advance one clock, updating the model from the inputs present before the edge.
  task automatic tick();
    bit   a_wr, head_live, head_dead, drain, enq;
    ent_t e;
    if (rst) begin
      q.delete();
      m_force = 0; m_conflict = 0; m_age = 0;
      exp_rw = 0; exp_wa = '0; exp_wd = '0;
    end else begin
      a_wr      = bus.a_valid && bus.a_addr != 5'd0;
      head_live = q.size() > 0 && !q[0].kill;
      head_dead = q.size() > 0 && q[0].kill;
      drain     = head_live && !bus.a_valid;
      enq       = bus.b_valid && q.size() < DEPTH && bus.b_addr != 5'd0 &&
                  !(a_wr && bus.a_addr == bus.b_addr);
      if (m_force && bus.a_valid) m_conflict = 1;
      if (drain || head_dead || q.size() == 0) begin
        m_force = 0;
        m_age   = 0;
      end else if (!m_force) begin
        m_age++;
        if (m_age == MAX_WAIT) m_force = 1;
      end
      exp_rw = a_wr || drain;
      if (a_wr) begin
        exp_wa = bus.a_addr; exp_wd = bus.a_data;
      end else if (drain) begin
        exp_wa = q[0].addr; exp_wd = q[0].data;
      end
      if (drain || head_dead) void'(q.pop_front());
      if (a_wr) foreach (q[i]) if (q[i].addr == bus.a_addr) q[i].kill = 1;
      if (enq) begin
        e.addr = bus.b_addr; e.data = bus.b_data; e.kill = 0;
        q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    tick(); tick();
    tests++;
    if ({bus.regwrite, bus.writeaddr, bus.writedata} !== '0) begin
      fails++;
      $display("FAIL reset_write: got rw=%0b wa=%0d wd=%0h want all 0",
               bus.regwrite, bus.writeaddr, bus.writedata);
    end
    tests++;
    if ({bus.stall, bus.busy, bus.conflict, bus.b_ready} !== 4'b0) begin
      fails++;
      $display("FAIL reset_flags: got stall/busy/conflict/b_ready=%b want 0000",
               {bus.stall, bus.busy, bus.conflict, bus.b_ready});
    end
    tests++;
    if (bus.pending !== 32'h0) begin
      fails++;
      $display("FAIL reset_pending: got %h want 0", bus.pending);
    end
    rst = 1'b0;
    tick();
    tests++;
    if (bus.b_ready !== 1'b1) begin
      fails++;
      $display("FAIL ready_after_reset: got %b want 1", bus.b_ready);
    end
  endtask

  task automatic test_a_write();
    drive(1, 5, 32'h11, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    tests++;
    if (bus.regwrite !== 1'b1 || bus.writeaddr !== 5'd5 || bus.writedata !== 32'h11) begin
      fails++;
      $display("FAIL a_write: got rw=%b wa=%0d wd=%h want rw=1 wa=5 wd=11",
               bus.regwrite, bus.writeaddr, bus.writedata);
    end
    tick();
    tests++;
    if (bus.regwrite !== 1'b0) begin
      fails++;
      $display("FAIL a_write_one_cycle: got rw=%b want 0", bus.regwrite);
    end
  endtask

  task automatic test_b_drain();
    drive(0, 0, 0, 1, 7, 32'hAA);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    tests++;
    if (bus.pending[7] !== 1'b1 || bus.busy !== 1'b1 || bus.regwrite !== 1'b0) begin
      fails++;
      $display("FAIL b_pending: got pend7=%b busy=%b rw=%b want 1 1 0",
               bus.pending[7], bus.busy, bus.regwrite);
    end
    tick();
    tests++;
    if (bus.regwrite !== 1'b1 || bus.writeaddr !== 5'd7 || bus.writedata !== 32'hAA ||
        bus.pending[7] !== 1'b0) begin
      fails++;
      $display("FAIL b_drain: got rw=%b wa=%0d wd=%h pend7=%b want 1 7 aa 0",
               bus.regwrite, bus.writeaddr, bus.writedata, bus.pending[7]);
    end
  endtask

  task automatic test_fill_force();
    int n = 0;
    bit seen = 0;
    for (int i = 1; i <= 4; i++) begin
      drive(1, 10 + i, $urandom, 1, i, 32'hB0 + i);
      tick(); n++;
    end
    tests++;
    if (bus.b_ready !== 1'b0 || bus.pending !== 32'h1E) begin
      fails++;
      $display("FAIL fifo_full: got b_ready=%b pending=%h want 0 0000001e",
               bus.b_ready, bus.pending);
    end
    drive(1, 20, $urandom, 1, 5, 32'h55);
    tick(); n++;
    tests++;
    if (bus.pending[5] !== 1'b0 || q.size() != 4) begin
      fails++;
      $display("FAIL full_push_refused: got pend5=%b want 0", bus.pending[5]);
    end
    for (int k = 0; k < 20 && !seen; k++) begin
      drive(1, 21, $urandom, 0, 0, 0);
      tick(); n++;
      if (bus.stall === 1'b1) seen = 1;
    end
    tests++;
    if (!seen || n != MAX_WAIT + 1) begin
      fails++;
      $display("FAIL force_entry: got stall=%b after %0d cycles want 1 after %0d",
               seen, n, MAX_WAIT + 1);
    end
    drive(0, 0, 0, 0, 0, 0);
    tick();
    tests++;
    if (bus.regwrite !== 1'b1 || bus.writeaddr !== 5'd1 || bus.writedata !== 32'hB1 ||
        bus.stall !== 1'b0) begin
      fails++;
      $display("FAIL force_drain: got rw=%b wa=%0d wd=%h stall=%b want 1 1 b1 0",
               bus.regwrite, bus.writeaddr, bus.writedata, bus.stall);
    end
    tick(); tick(); tick();
    tests++;
    if (bus.busy !== 1'b0 || bus.writeaddr !== 5'd4 || bus.conflict !== 1'b0) begin
      fails++;
      $display("FAIL fill_drained: got busy=%b last_wa=%0d conflict=%b want 0 4 0",
               bus.busy, bus.writeaddr, bus.conflict);
    end
  endtask

  task automatic test_kill();
    drive(1, 20, 32'h0, 1, 9, 32'h1);
    tick();
    drive(1, 9, 32'h2, 0, 0, 0);
    tick();
    tests++;
    if (bus.regwrite !== 1'b1 || bus.writeaddr !== 5'd9 || bus.writedata !== 32'h2 ||
        bus.pending[9] !== 1'b0) begin
      fails++;
      $display("FAIL kill_a_write: got rw=%b wa=%0d wd=%h pend9=%b want 1 9 2 0",
               bus.regwrite, bus.writeaddr, bus.writedata, bus.pending[9]);
    end
    drive(0, 0, 0, 0, 0, 0);
    tick();
    tests++;
    if (bus.regwrite !== 1'b0 || bus.busy !== 1'b0 || bus.pending !== 32'h0) begin
      fails++;
      $display("FAIL kill_pop: got rw=%b busy=%b pending=%h want 0 0 0",
               bus.regwrite, bus.busy, bus.pending);
    end
  endtask

  task automatic test_same_cycle();
    drive(1, 3, 32'h33, 1, 3, 32'h44);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    tests++;
    if (bus.regwrite !== 1'b1 || bus.writedata !== 32'h33 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL same_cycle: got rw=%b wd=%h busy=%b want 1 33 0",
               bus.regwrite, bus.writedata, bus.busy);
    end
    tick();
    tests++;
    if (bus.regwrite !== 1'b0) begin
      fails++;
      $display("FAIL same_cycle_no_b: got rw=%b want 0", bus.regwrite);
    end
    drive(0, 0, 0, 1, 0, 32'h77);
    tests++;
    if (bus.b_ready !== 1'b1) begin
      fails++;
      $display("FAIL r0_ready: got %b want 1", bus.b_ready);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0);
    tick();
    tests++;
    if (bus.regwrite !== 1'b0 || bus.busy !== 1'b0 || bus.pending !== 32'h0) begin
      fails++;
      $display("FAIL r0_discard: got rw=%b busy=%b pending=%h want 0 0 0",
               bus.regwrite, bus.busy, bus.pending);
    end
  endtask

  task automatic test_conflict();
    bit seen = 0;
    drive(1, 21, 32'h0, 1, 6, 32'h66);
    tick();
    for (int k = 0; k < 20 && !seen; k++) begin
      drive(1, 21, 32'h0, 0, 0, 0);
      tick();
      if (bus.stall === 1'b1) seen = 1;
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL conflict_force: got stall=0 want 1 within 20 cycles");
    end
    drive(1, 22, 32'h5, 0, 0, 0);
    tick();
    tests++;
    if (bus.regwrite !== 1'b1 || bus.writeaddr !== 5'd22 || bus.conflict !== 1'b1 ||
        bus.stall !== 1'b1) begin
      fails++;
      $display("FAIL conflict_set: got rw=%b wa=%0d conflict=%b stall=%b want 1 22 1 1",
               bus.regwrite, bus.writeaddr, bus.conflict, bus.stall);
    end
    drive(0, 0, 0, 0, 0, 0);
    tick(); tick();
    tests++;
    if (bus.conflict !== 1'b1 || bus.stall !== 1'b0 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL conflict_sticky: got conflict=%b stall=%b busy=%b want 1 0 0",
               bus.conflict, bus.stall, bus.busy);
    end
    drive(1, 23, 32'h0, 1, 8, 32'h88);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    tick();
    tests++;
    if ({bus.regwrite, bus.writeaddr, bus.writedata, bus.stall, bus.pending, bus.busy,
         bus.conflict, bus.b_ready} !== '0) begin
      fails++;
      $display("FAIL reset_clears: got rw=%b stall=%b pend=%h busy=%b conflict=%b want all 0",
               bus.regwrite, bus.stall, bus.pending, bus.busy, bus.conflict);
    end
    rst = 1'b0;
    tick();
    tests++;
    if (bus.busy !== 1'b0 || bus.regwrite !== 1'b0) begin
      fails++;
      $display("FAIL reset_discard: got busy=%b rw=%b want 0 0", bus.busy, bus.regwrite);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      drive($urandom_range(0, 99) < 65, $urandom_range(0, 7), $urandom,
            $urandom_range(0, 1), $urandom_range(0, 7), $urandom);
      tick();
      tests++;
      if (bus.regwrite !== exp_rw || (exp_rw && (bus.writeaddr !== exp_wa ||
                                                 bus.writedata !== exp_wd))) begin
        fails++;
        $display("FAIL rand_write c=%0d: got rw=%b wa=%0d wd=%h want rw=%b wa=%0d wd=%h",
                 c, bus.regwrite, bus.writeaddr, bus.writedata, exp_rw, exp_wa, exp_wd);
      end
      tests++;
      if (bus.pending !== model_pending() || bus.busy !== (q.size() > 0)) begin
        fails++;
        $display("FAIL rand_pending c=%0d: got pend=%h busy=%b want pend=%h busy=%b",
                 c, bus.pending, bus.busy, model_pending(), q.size() > 0);
      end
      tests++;
      if (bus.stall !== m_force || bus.conflict !== m_conflict ||
          bus.b_ready !== (!rst && q.size() < DEPTH)) begin
        fails++;
        $display("FAIL rand_ctrl c=%0d: got stall=%b conflict=%b rdy=%b want %b %b %b",
                 c, bus.stall, bus.conflict, bus.b_ready, m_force, m_conflict,
                 (!rst && q.size() < DEPTH));
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0);
    test_reset();
    test_a_write();
    test_b_drain();
    test_fill_force();
    test_kill();
    test_same_cycle();
    test_conflict();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
